// File: rtl/mtimer_pkg.sv
// Shared constants and byte-merge helper for the machine timer.
`include "mtimer.vh"

package mtimer_pkg;

    localparam logic [3:0]  MTIME_LO     = `MTIMER_MTIME_LO;
    localparam logic [3:0]  MTIME_HI     = `MTIMER_MTIME_HI;
    localparam logic [3:0]  MTIMECMP_LO  = `MTIMER_MTIMECMP_LO;
    localparam logic [3:0]  MTIMECMP_HI  = `MTIMER_MTIMECMP_HI;
    localparam logic [63:0] MTIMECMP_RST = `MTIMER_MTIMECMP_RST;

    // Replace only the byte lanes whose strobe is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  be);
        logic [31:0] merged;
        merged = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/mtimer.vh
// Register offsets and reset constants shared by the mtimer RTL and anything
// that needs to address it.
`ifndef MTIMER_VH
`define MTIMER_VH

`define MTIMER_MTIME_LO      4'h0
`define MTIMER_MTIME_HI      4'h4
`define MTIMER_MTIMECMP_LO   4'h8
`define MTIMER_MTIMECMP_HI   4'hC
`define MTIMER_MTIMECMP_RST  64'hFFFF_FFFF_FFFF_FFFF

`endif

// File: rtl/mtimer_prescaler.sv
// Tick generator for mtime: one-cycle pulse every PRESCALE clk cycles.
module mtimer_prescaler #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] count;

    // The pulse covers the cycle whose edge wraps the count back to zero.
    assign tick = (count == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/mtimer.sv
// Machine timer: 64-bit mtime/mtimecmp with byte-strobed bus access.
// Define MTIMER_PRESCALER_EN to advance mtime once every PRESCALE clk cycles.
import mtimer_pkg::*;

module mtimer #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wenable,
    output logic [31:0] rdata,
    output logic        mti_pending
);

    if (PRESCALE < 2 || PRESCALE > 65535) begin : g_bad_prescale
        $error("mtimer: PRESCALE must be in 2..65535");
    end

    logic        tick;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        wr_any;
    logic        wr_time_lo;
    logic        wr_time_hi;
    logic        wr_cmp_lo;
    logic        wr_cmp_hi;
    logic [1:0]  addr_unused;

    assign addr_unused = addr[1:0];

`ifdef MTIMER_PRESCALER_EN
    mtimer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );
`else
    assign tick = 1'b1;
`endif

    assign wr_any     = sel && (wenable != 4'b0000);
    assign wr_time_lo = wr_any && (addr[3:2] == MTIME_LO[3:2]);
    assign wr_time_hi = wr_any && (addr[3:2] == MTIME_HI[3:2]);
    assign wr_cmp_lo  = wr_any && (addr[3:2] == MTIMECMP_LO[3:2]);
    assign wr_cmp_hi  = wr_any && (addr[3:2] == MTIMECMP_HI[3:2]);

    always_comb begin
        rdata = 32'h0;
        if (sel) begin
            case (addr[3:2])
                MTIME_LO[3:2]:    rdata = mtime[31:0];
                MTIME_HI[3:2]:    rdata = mtime[63:32];
                MTIMECMP_LO[3:2]: rdata = mtimecmp[31:0];
                default:          rdata = mtimecmp[63:32];
            endcase
        end
    end

    // A software write to either mtime word wins over the tick, so no carry
    // ever propagates into freshly written bytes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mtime       <= '0;
            mtimecmp    <= MTIMECMP_RST;
            mti_pending <= 1'b0;
        end else begin
            mti_pending <= (mtime >= mtimecmp);
            if (wr_time_lo) begin
                mtime[31:0] <= merge_bytes(mtime[31:0], wdata, wenable);
            end else if (wr_time_hi) begin
                mtime[63:32] <= merge_bytes(mtime[63:32], wdata, wenable);
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
            if (wr_cmp_lo) begin
                mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], wdata, wenable);
            end
            if (wr_cmp_hi) begin
                mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], wdata, wenable);
            end
        end
    end

endmodule
